// File: rtl/level_ctrl.sv
// level_ctrl: per-level enemy/lives/key bookkeeping and timed spawn scheduler; define LEVEL_CTRL_INVULN_EN for a post-hit invulnerability window
module level_ctrl #(
  parameter int LIFE_W     = 2,
  parameter int LIVES_INIT = 3,
  parameter int ENEMY_W    = 4,
  parameter int N_L0       = 4,
  parameter int N_L1       = 6,
  parameter int N_L2       = 8,
  parameter int N_L3       = 1,
  parameter int TIMER_W    = 16,
  parameter int SPAWN_DIV  = 1000,
  parameter int INVULN_CYC = 64
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Level_Start,
  input  logic [1:0]         Level,
  input  logic               Kill,
  input  logic               Hit,
  input  logic               Key_Pick,
  input  logic               Spawn_Ack,
  output logic               Spawn_Req,
  output logic [ENEMY_W-1:0] Spawn_Id,
  output logic [LIFE_W-1:0]  Lives,
  output logic [ENEMY_W-1:0] Enemies_Left,
  output logic               Enemies_Zero,
  output logic               Lives_Zero,
  output logic               Key_Held,
  output logic               Busy
);
  typedef enum logic [2:0] {IDLE, LOAD, SPAWN_WAIT, SPAWN_REQ, ACTIVE, CLEAR, DEAD} state_t;
  state_t state_q, state_d;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic [ENEMY_W-1:0] pending_q, pending_d, alive_q, alive_d;
  logic [ENEMY_W-1:0] spawn_id_q, spawn_id_d, left_q, left_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic key_q, key_d, req_q, req_d, ez_q, ez_d, lz_q, lz_d, busy_q, busy_d;
  logic busy, live, kill_ok, ack_ok, hit_ok, hit_dec, inv_ok;
  logic [ENEMY_W-1:0] quota;

  assign quota = Level == 2'd0 ? ENEMY_W'(N_L0) :
                 Level == 2'd1 ? ENEMY_W'(N_L1) :
                 Level == 2'd2 ? ENEMY_W'(N_L2) : ENEMY_W'(N_L3);

`ifdef LEVEL_CTRL_INVULN_EN
  localparam int INV_W = INVULN_CYC < 1 ? 1 : $clog2(INVULN_CYC + 1);
  logic [INV_W-1:0] inv_q, inv_d;
  assign inv_ok = inv_q == '0;
  // window reloads on a life-costing hit and counts down to zero; a new level drops it
  always_comb inv_d = Level_Start ? '0 : hit_dec ? INV_W'(INVULN_CYC) : inv_q - INV_W'(inv_q != '0);
  // invulnerability counter register
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) inv_q <= '0;
    else inv_q <= inv_d;
`else
  // without the window every hit counts; the window length has no effect
  assign inv_ok = INVULN_CYC >= 0;
`endif

  // next state, counters, and the registered status outputs derived from the next state
  always_comb begin
    busy = state_q inside {LOAD, SPAWN_WAIT, SPAWN_REQ, ACTIVE};
    live = busy || state_q == CLEAR;
    kill_ok = Kill && busy && alive_q != '0;
    ack_ok = Spawn_Ack && state_q == SPAWN_REQ;
    hit_ok = Hit && live && inv_ok;
    hit_dec = 1'b0;
    state_d = state_q;
    lives_d = lives_q;
    pending_d = pending_q;
    alive_d = alive_q;
    spawn_id_d = spawn_id_q;
    timer_d = timer_q;
    key_d = key_q;
    if (Level_Start) begin
      state_d = LOAD;
      pending_d = quota;
      alive_d = '0;
      spawn_id_d = '0;
      timer_d = '0;
      key_d = 1'b0;
      lives_d = Level == 2'd0 ? LIFE_W'(LIVES_INIT) : lives_q;
    end else begin
      pending_d = pending_q - ENEMY_W'(ack_ok);
      alive_d = alive_q + ENEMY_W'(ack_ok) - ENEMY_W'(kill_ok);
      spawn_id_d = spawn_id_q + ENEMY_W'(ack_ok);
      key_d = key_q || (Key_Pick && live);
      hit_dec = hit_ok && lives_q != '0;
      lives_d = lives_q - LIFE_W'(hit_dec);
      case (state_q)
        LOAD: begin
          state_d = SPAWN_WAIT;
          timer_d = '0;
        end
        SPAWN_WAIT: begin
          timer_d = timer_q + TIMER_W'(1);
          state_d = timer_q == TIMER_W'(SPAWN_DIV - 1) ? SPAWN_REQ : SPAWN_WAIT;
        end
        SPAWN_REQ: begin
          timer_d = '0;
          state_d = !ack_ok ? SPAWN_REQ : pending_d == '0 ? ACTIVE : SPAWN_WAIT;
        end
        ACTIVE: state_d = pending_d == '0 && alive_d == '0 ? CLEAR : ACTIVE;
        default: state_d = state_q;
      endcase
      if (hit_ok && lives_d == '0) state_d = DEAD;
    end
    req_d = state_d == SPAWN_REQ;
    ez_d = state_d == CLEAR;
    busy_d = state_d inside {LOAD, SPAWN_WAIT, SPAWN_REQ, ACTIVE};
    lz_d = lives_d == '0;
    left_d = pending_d + alive_d;
  end

  // state, counter and output registers
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      lives_q <= LIFE_W'(LIVES_INIT);
      pending_q <= '0;
      alive_q <= '0;
      spawn_id_q <= '0;
      timer_q <= '0;
      key_q <= 1'b0;
      req_q <= 1'b0;
      ez_q <= 1'b0;
      lz_q <= LIVES_INIT == 0;
      busy_q <= 1'b0;
      left_q <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      pending_q <= pending_d;
      alive_q <= alive_d;
      spawn_id_q <= spawn_id_d;
      timer_q <= timer_d;
      key_q <= key_d;
      req_q <= req_d;
      ez_q <= ez_d;
      lz_q <= lz_d;
      busy_q <= busy_d;
      left_q <= left_d;
    end

  assign Spawn_Req = req_q;
  assign Spawn_Id = spawn_id_q;
  assign Lives = lives_q;
  assign Enemies_Left = left_q;
  assign Enemies_Zero = ez_q;
  assign Lives_Zero = lz_q;
  assign Key_Held = key_q;
  assign Busy = busy_q;
endmodule

// File: tb/tb_level_ctrl.sv
// tb_level_ctrl: scoreboard bench for level_ctrl with SPAWN_DIV=4
module tb_level_ctrl;
  logic Clk = 1'b0;
  logic Reset_n, Level_Start, Kill, Hit, Key_Pick, Spawn_Ack;
  logic [1:0] Level;
  logic Spawn_Req, Enemies_Zero, Lives_Zero, Key_Held, Busy;
  logic [3:0] Spawn_Id, Enemies_Left;
  logic [1:0] Lives;

  level_ctrl #(.SPAWN_DIV(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Level_Start(Level_Start), .Level(Level),
    .Kill(Kill), .Hit(Hit), .Key_Pick(Key_Pick), .Spawn_Ack(Spawn_Ack),
    .Spawn_Req(Spawn_Req), .Spawn_Id(Spawn_Id), .Lives(Lives),
    .Enemies_Left(Enemies_Left), .Enemies_Zero(Enemies_Zero),
    .Lives_Zero(Lives_Zero), .Key_Held(Key_Held), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int exp_cyc[$];
  logic [14:0] exp_v[$];
  string exp_n[$];
  logic [3:0] spawn_q[$];
  logic prev_req = 1'b0;
  logic done = 1'b0;
  logic final_done = 1'b0;
  logic [14:0] act;

  assign act = {Spawn_Req, Spawn_Id, Lives, Enemies_Left, Enemies_Zero, Lives_Zero, Key_Held, Busy};

  function automatic logic [14:0] v(int r, int id, int l, int left, int ez, int lz, int k, int b);
    return {1'(r), 4'(id), 2'(l), 4'(left), 1'(ez), 1'(lz), 1'(k), 1'(b)};
  endfunction

  task automatic ex(int off, string n, logic [14:0] val);
    exp_cyc.push_back(cyc + off);
    exp_v.push_back(val);
    exp_n.push_back(n);
  endtask

  task automatic go(int ls, int lvl, int k, int h, int kp, int a);
    Level_Start = 1'(ls);
    Level = 2'(lvl);
    Kill = 1'(k);
    Hit = 1'(h);
    Key_Pick = 1'(kp);
    Spawn_Ack = 1'(a);
    @(posedge Clk);
    #1;
    Level_Start = 1'b0;
    Level = 2'd0;
    Kill = 1'b0;
    Hit = 1'b0;
    Key_Pick = 1'b0;
    Spawn_Ack = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) go(0, 0, 0, 0, 0, 0);
  endtask

  // monitor: status snapshots by cycle, spawn ids on each Spawn_Req rise
  initial forever begin
    @(negedge Clk);
    while (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
      checks++;
      if (exp_cyc[0] != cyc || act !== exp_v[0]) begin
        failures++;
        $display("FAIL %s cyc=%0d due=%0d got=%h want=%h", exp_n[0], cyc, exp_cyc[0], act, exp_v[0]);
      end
      exp_cyc.delete(0);
      exp_v.delete(0);
      exp_n.delete(0);
    end
    if (Spawn_Req === 1'b1 && prev_req !== 1'b1) begin
      checks++;
      if (spawn_q.size() == 0) begin
        failures++;
        $display("FAIL spawn_unexpected cyc=%0d got_id=%0d want=none", cyc, Spawn_Id);
      end else begin
        if (Spawn_Id !== spawn_q[0]) begin
          failures++;
          $display("FAIL spawn_id cyc=%0d got=%0d want=%0d", cyc, Spawn_Id, spawn_q[0]);
        end
        spawn_q.delete(0);
      end
    end
    prev_req = Spawn_Req;
    if (done && !final_done) begin
      checks++;
      if (exp_cyc.size() != 0 || spawn_q.size() != 0) begin
        failures++;
        $display("FAIL leftover got_snap=%0d got_spawn=%0d want=0", exp_cyc.size(), spawn_q.size());
      end
      final_done = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    Level_Start = 1'b0;
    Level = 2'd0;
    Kill = 1'b0;
    Hit = 1'b0;
    Key_Pick = 1'b0;
    Spawn_Ack = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    ex(0, "reset", v(0, 0, 3, 0, 0, 0, 0, 0));
    // level 0 spawn timing, kill+ack overlap, key, hit
    ex(1, "a_load", v(0, 0, 3, 4, 0, 0, 0, 1));
    ex(2, "a_wait", v(0, 0, 3, 4, 0, 0, 0, 1));
    ex(5, "a_wait_last", v(0, 0, 3, 4, 0, 0, 0, 1));
    ex(6, "a_req0", v(1, 0, 3, 4, 0, 0, 0, 1));
    ex(7, "a_ack0", v(0, 1, 3, 4, 0, 0, 0, 1));
    ex(11, "a_req1", v(1, 1, 3, 4, 0, 0, 0, 1));
    ex(12, "a_ack1", v(0, 2, 3, 4, 0, 0, 0, 1));
    ex(13, "a_kill", v(0, 2, 3, 3, 0, 0, 0, 1));
    ex(16, "a_req2", v(1, 2, 3, 3, 0, 0, 0, 1));
    ex(17, "a_kill_ack", v(0, 3, 3, 2, 0, 0, 0, 1));
    ex(18, "a_key", v(0, 3, 3, 2, 0, 0, 1, 1));
    ex(19, "a_hit", v(0, 3, 2, 2, 0, 0, 1, 1));
    spawn_q.push_back(4'd0);
    spawn_q.push_back(4'd1);
    spawn_q.push_back(4'd2);
    go(1, 0, 0, 0, 0, 0);
    idle(5);
    go(0, 0, 0, 0, 0, 1);
    idle(4);
    go(0, 0, 0, 0, 0, 1);
    go(0, 0, 1, 0, 0, 0);
    idle(3);
    go(0, 0, 1, 0, 0, 1);
    go(0, 0, 0, 0, 1, 0);
    go(0, 0, 0, 1, 0, 0);
    // level 1 aborted mid-request by level 2 start, hit and ack that cycle ignored
    ex(1, "b_load1", v(0, 0, 2, 6, 0, 0, 0, 1));
    ex(6, "b_req_l1", v(1, 0, 2, 6, 0, 0, 0, 1));
    ex(7, "b_abort", v(0, 0, 2, 8, 0, 0, 0, 1));
    ex(12, "b_req_l2", v(1, 0, 2, 8, 0, 0, 0, 1));
    spawn_q.push_back(4'd0);
    spawn_q.push_back(4'd0);
    go(1, 1, 0, 0, 0, 0);
    idle(5);
    go(1, 2, 0, 1, 0, 1);
    idle(5);
    // new game, three hits to DEAD, frozen in DEAD, restart reloads lives
    ex(1, "c_newgame", v(0, 0, 3, 4, 0, 0, 0, 1));
    ex(6, "c_req", v(1, 0, 3, 4, 0, 0, 0, 1));
    ex(7, "c_hit1", v(1, 0, 2, 4, 0, 0, 0, 1));
    ex(8, "c_hit2", v(1, 0, 1, 4, 0, 0, 0, 1));
    ex(9, "c_dead", v(0, 0, 0, 4, 0, 1, 0, 0));
    ex(10, "c_dead_frozen", v(0, 0, 0, 4, 0, 1, 0, 0));
    ex(11, "c_restart", v(0, 0, 3, 4, 0, 0, 0, 1));
    spawn_q.push_back(4'd0);
    go(1, 0, 0, 0, 0, 0);
    idle(5);
    go(0, 0, 0, 1, 0, 0);
    go(0, 0, 0, 1, 0, 0);
    go(0, 0, 0, 1, 0, 0);
    go(0, 0, 1, 1, 1, 1);
    go(1, 0, 0, 0, 0, 0);
    // level 3 single enemy to CLEAR; kill with nothing alive ignored; hit and key in CLEAR
    ex(1, "d_load3", v(0, 0, 3, 1, 0, 0, 0, 1));
    ex(3, "d_kill_none", v(0, 0, 3, 1, 0, 0, 0, 1));
    ex(6, "d_req", v(1, 0, 3, 1, 0, 0, 0, 1));
    ex(7, "d_active", v(0, 1, 3, 1, 0, 0, 0, 1));
    ex(8, "d_clear", v(0, 1, 3, 0, 1, 0, 0, 0));
    ex(9, "d_clear_hold", v(0, 1, 3, 0, 1, 0, 0, 0));
    ex(10, "d_clear_hit_key", v(0, 1, 2, 0, 1, 0, 1, 0));
    spawn_q.push_back(4'd0);
    go(1, 3, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0);
    go(0, 0, 1, 0, 0, 0);
    idle(3);
    go(0, 0, 0, 0, 0, 1);
    go(0, 0, 1, 0, 0, 0);
    idle(1);
    go(0, 0, 0, 1, 1, 0);
    idle(2);
    done = 1'b1;
    repeat (3) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/level_ctrl.md
Name: level_ctrl

Overview:
- Per-level enemy/lives/key bookkeeper and spawn scheduler beneath the top-level game state machine.
- On each level start it loads the level's enemy quota and issues spawns to the sprite/enemy datapath on a fixed interval, with a req/ack handshake.
- It counts kills and hits, and tracks key pickup.
- It produces the Enemies/Lives/Keys status the game state machine consumes to advance levels or return to the initial state.

Parameters:
- LIFE_W, 2, lives counter width.
- LIVES_INIT, 3, lives loaded on reset and on a new game (Level_Start with Level==0).
- ENEMY_W, 4, width of the enemy counters and Spawn_Id.
- N_L0 / N_L1 / N_L2 / N_L3, 4 / 6 / 8 / 1, enemy quota for levels 0..3. Each value is 1..2^ENEMY_W-1.
- TIMER_W, 16, spawn timer width.
- SPAWN_DIV, 1000, cycles between spawns (>=1).
- INVULN_CYC, 64, invulnerability window length (optional feature only).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- Level_Start  in  1  one-cycle pulse: begin level given by Level.
- Level  in  2  level index 0..3; sampled only with Level_Start.
- Kill  in  1  pulse: one live enemy destroyed.
- Hit  in  1  pulse: player hit.
- Key_Pick  in  1  pulse: key collected.
- Spawn_Ack  in  1  datapath accepted current spawn.
- Spawn_Req  out  1  spawn request, held until acked.
- Spawn_Id  out  ENEMY_W  index of enemy being spawned, 0-based within level.
- Lives  out  LIFE_W  remaining lives.
- Enemies_Left  out  ENEMY_W  pending + alive.
- Enemies_Zero  out  1  level cleared.
- Lives_Zero  out  1  Lives==0.
- Key_Held  out  1  key collected this level.
- Busy  out  1  level in progress (LOAD, SPAWN_WAIT, SPAWN_REQ, ACTIVE).

Behaviour:
- Reset values:
  - State IDLE.
  - Lives = LIVES_INIT.
  - pending = 0, alive = 0, timer = 0, Spawn_Id = 0.
  - All 1-bit outputs 0, except Lives_Zero = (LIVES_INIT==0).
- States: IDLE, LOAD, SPAWN_WAIT, SPAWN_REQ, ACTIVE, CLEAR, DEAD. All outputs are registered.
- Level_Start in any state (abort mid-level included):
  - Next state LOAD.
  - pending = N_L[Level], alive = 0, Spawn_Id = 0, Key_Held = 0, Spawn_Req = 0.
  - If Level==0, Lives reloads LIVES_INIT.
  - Level_Start has priority over every other event that cycle.
- LOAD -> SPAWN_WAIT unconditionally; timer cleared.
- SPAWN_WAIT:
  - Timer increments each cycle.
  - When timer==SPAWN_DIV-1, go to SPAWN_REQ.
  - Spawn_Req rises exactly SPAWN_DIV cycles after entry to SPAWN_WAIT.
- SPAWN_REQ:
  - Spawn_Req=1, Spawn_Id stable.
  - On Spawn_Ack: pending-1, alive+1, Spawn_Id+1, Spawn_Req drops next cycle.
  - Then go to ACTIVE if the new pending==0, else SPAWN_WAIT (timer cleared).
  - Spawn_Ack outside SPAWN_REQ is ignored.
- Kill:
  - Decrements alive in any Busy state.
  - Ignored when alive==0.
  - Kill and Spawn_Ack in the same cycle: alive unchanged, pending-1.
- ACTIVE -> CLEAR when pending==0 and alive==0 (evaluated on the updated counts, so the last Kill enters CLEAR next cycle).
- Enemies_Zero=1 only in CLEAR. It is 0 in IDLE/LOAD, so the game state machine never sees a false clear.
- CLEAR holds until Level_Start.
- Hit:
  - In Busy or CLEAR: Lives-1, saturating at 0.
  - When Lives reaches 0: go to DEAD, Spawn_Req=0, Lives_Zero=1.
  - Hit ignored in IDLE/DEAD.
  - Kill and Hit in the same cycle are both applied.
- DEAD: counters frozen; only Level_Start leaves it.
- Key_Pick sets Key_Held in Busy or CLEAR; it is sticky until Level_Start or reset.
- Enemies_Left = pending+alive. Never wraps, since the sum is at most N_L[Level].

Optional Feature:
- Macro LEVEL_CTRL_INVULN_EN.
- Defined:
  - A Hit that decrements Lives starts a counter of INVULN_CYC cycles.
  - Further Hits during the window are ignored.
  - The window is cleared by Level_Start and reset.
- Undefined: every Hit decrements Lives (saturating); no counter is instantiated.

Test Plan:
- SPAWN_DIV=4, Level_Start with Level=0 at cycle 0 -> LOAD at 1, SPAWN_WAIT at 2, Spawn_Req=1 at 6 with Spawn_Id=0, Enemies_Left=4. Ack at 6 -> Spawn_Req=0 at 7, Spawn_Req again at 11 with Id=1.
- Level 3 (N_L3=1): ack the single spawn, then Kill -> ACTIVE, then CLEAR one cycle after Kill, Enemies_Zero=1, Busy=0, Enemies_Left=0.
- Kill and Spawn_Ack in the same cycle with alive=1, pending=2 -> alive=1, pending=1, Enemies_Left=2.
- Three Hits (LIVES_INIT=3, feature off) -> Lives 2,1,0; DEAD, Lives_Zero=1, Spawn_Req=0. A fourth Hit leaves Lives=0. Level_Start with Level=0 -> Lives=3, Lives_Zero=0.
- Level_Start with Level=2 mid-SPAWN_REQ of level 1 -> Spawn_Req=0 next cycle, pending=8, Key_Held=0, Lives retained.
- LEVEL_CTRL_INVULN_EN defined, INVULN_CYC=8, Hits at cycles 0 and 5 -> Lives 3->2 only. A Hit at cycle 9 -> Lives=1.
